// File: rtl/uart_cmd_enc_pkg.sv
// Shared definitions for the UART command encoder: frame opcodes, command types,
// frame/bit FSM state encodings and the frame-length table.
package uart_cmd_enc_pkg;

   localparam logic [7:0] OP_REG_WR  = 8'hAA;
   localparam logic [7:0] OP_REG_RD  = 8'hBB;
   localparam logic [7:0] OP_ALU_OP  = 8'hCC;
   localparam logic [7:0] OP_ALU_NOP = 8'hDD;

   typedef enum logic [1:0] {
      CMD_REG_WR  = 2'd0,
      CMD_REG_RD  = 2'd1,
      CMD_ALU_OP  = 2'd2,
      CMD_ALU_NOP = 2'd3
   } cmd_type_t;

   typedef enum logic [2:0] {
      F_IDLE,
      F_LOAD,
      F_SEND,
      F_GAP,
      F_DONE
   } frame_state_t;

   typedef enum logic [2:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_PARITY,
      B_STOP
   } bit_state_t;

   // Index of the last byte of a frame (frame length minus one).
   function automatic logic [1:0] frame_last(cmd_type_t t);
      case (t)
         CMD_REG_WR: return 2'd2;
         CMD_REG_RD: return 2'd1;
         CMD_ALU_OP: return 2'd3;
         default:    return 2'd1;
      endcase
   endfunction

endpackage

// File: rtl/uart_char_tx.sv
// One-character UART shifter: start bit, DATA_WIDTH bits LSB first, optional parity, stop bit.
// A load in the last stop-bit cycle chains the next character with no idle time.
//  state    | meaning
//  B_IDLE   | line high, waiting for load
//  B_START  | start bit (0)
//  B_DATA   | data bits, LSB first
//  B_PARITY | parity bit
//  B_STOP   | stop bit (1); char_end on its last cycle
module uart_char_tx
   import uart_cmd_enc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TICK_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic [TICK_WIDTH-1:0] ticks,
   output logic                  tx,
   output logic                  char_end
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

   bit_state_t            state;
   logic [TICK_WIDTH-1:0] tick_cnt;
   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shift;
   logic                  par_bit;
   logic                  tick_done;
   logic                  load_ok;

   assign tick_done = (tick_cnt == '0);
   assign char_end  = (state == B_STOP) && tick_done;
   assign load_ok   = load && ((state == B_IDLE) || char_end);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= B_IDLE;
         tx       <= 1'b1;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
      end else if (load_ok) begin
         state    <= B_START;
         tx       <= 1'b0;
         tick_cnt <= ticks - 1'b1;
         bit_cnt  <= '0;
         shift    <= data;
         par_bit  <= (^data) ^ par_typ;
      end else if (state != B_IDLE) begin
         if (!tick_done) begin
            tick_cnt <= tick_cnt - 1'b1;
         end else begin
            tick_cnt <= ticks - 1'b1;
            case (state)
               B_START: begin
                  state <= B_DATA;
                  tx    <= shift[0];
                  shift <= shift >> 1;
               end
               B_DATA: begin
                  if (bit_cnt == BIT_LAST) begin
                     if (par_en) begin
                        state <= B_PARITY;
                        tx    <= par_bit;
                     end else begin
                        state <= B_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx      <= shift[0];
                     shift   <= shift >> 1;
                  end
               end
               B_PARITY: begin
                  state <= B_STOP;
                  tx    <= 1'b1;
               end
               default: begin
                  state    <= B_IDLE;
                  tx       <= 1'b1;
                  tick_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/uart_cmd_encoder.sv
// Command-to-UART frame encoder: builds opcode + operand bytes and sends them via uart_char_tx.
// Build option UART_CMD_ENC_IDLE_GAP_EN inserts GAP_BITS idle bit-times between characters.
//  state  | meaning
//  F_IDLE | ready for a command
//  F_LOAD | first byte handed to the character shifter
//  F_SEND | character in flight; chain next byte or finish
//  F_GAP  | idle gap between characters (gap build only)
//  F_DONE | one-cycle FRAME_DONE, ready for the next command
module uart_cmd_encoder
   import uart_cmd_enc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUNC_WIDTH = 4,
   parameter int TICK_WIDTH = 8,
   parameter int GAP_BITS   = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CMD_VALID,
   output logic                  CMD_READY,
   input  logic [1:0]            CMD_TYPE,
   input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
   input  logic [DATA_WIDTH-1:0] CMD_DATA0,
   input  logic [DATA_WIDTH-1:0] CMD_DATA1,
   input  logic [FUNC_WIDTH-1:0] CMD_FUNC,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [TICK_WIDTH-1:0] BIT_TICKS,
   output logic                  TX_OUT,
   output logic                  BUSY,
   output logic                  FRAME_DONE
);

   frame_state_t          state;
   cmd_type_t             type_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] d0_q;
   logic [DATA_WIDTH-1:0] d1_q;
   logic [FUNC_WIDTH-1:0] func_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [TICK_WIDTH-1:0] ticks_q;
   logic [1:0]            byte_cnt;
   logic                  accept;
   logic                  last_byte;
   logic                  load;
   logic [1:0]            load_idx;
   logic [DATA_WIDTH-1:0] load_byte;
   logic                  char_end;

`ifdef UART_CMD_ENC_IDLE_GAP_EN
   localparam int GAP_W = TICK_WIDTH + $clog2(GAP_BITS + 1);
   logic [GAP_W-1:0] gap_cnt;
   logic [GAP_W-1:0] gap_len;
   assign gap_len = GAP_W'(GAP_BITS) * GAP_W'(ticks_q);
`endif

   assign accept    = CMD_VALID && CMD_READY;
   assign last_byte = (byte_cnt == frame_last(type_q));

   always_comb begin
      load     = 1'b0;
      load_idx = byte_cnt + 2'd1;
      case (state)
         F_LOAD: begin
            load     = 1'b1;
            load_idx = 2'd0;
         end
`ifdef UART_CMD_ENC_IDLE_GAP_EN
         F_GAP:  load = (gap_cnt == '0);
`else
         F_SEND: load = char_end && !last_byte;
`endif
         default: load = 1'b0;
      endcase
   end

   always_comb begin
      load_byte = '0;
      case (type_q)
         CMD_REG_WR:
            case (load_idx)
               2'd0:    load_byte = DATA_WIDTH'(OP_REG_WR);
               2'd1:    load_byte = DATA_WIDTH'(addr_q);
               default: load_byte = d0_q;
            endcase
         CMD_REG_RD:
            load_byte = (load_idx == 2'd0) ? DATA_WIDTH'(OP_REG_RD) : DATA_WIDTH'(addr_q);
         CMD_ALU_OP:
            case (load_idx)
               2'd0:    load_byte = DATA_WIDTH'(OP_ALU_OP);
               2'd1:    load_byte = d0_q;
               2'd2:    load_byte = d1_q;
               default: load_byte = DATA_WIDTH'(func_q);
            endcase
         default:
            load_byte = (load_idx == 2'd0) ? DATA_WIDTH'(OP_ALU_NOP) : DATA_WIDTH'(func_q);
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= F_IDLE;
         CMD_READY  <= 1'b1;
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
         type_q     <= CMD_REG_WR;
         addr_q     <= '0;
         d0_q       <= '0;
         d1_q       <= '0;
         func_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         ticks_q    <= '0;
         byte_cnt   <= '0;
`ifdef UART_CMD_ENC_IDLE_GAP_EN
         gap_cnt    <= '0;
`endif
      end else begin
         FRAME_DONE <= 1'b0;
         case (state)
            F_IDLE, F_DONE: begin
               if (accept) begin
                  state     <= F_LOAD;
                  CMD_READY <= 1'b0;
                  BUSY      <= 1'b1;
                  type_q    <= cmd_type_t'(CMD_TYPE);
                  addr_q    <= CMD_ADDR;
                  d0_q      <= CMD_DATA0;
                  d1_q      <= CMD_DATA1;
                  func_q    <= CMD_FUNC;
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
                  ticks_q   <= (BIT_TICKS == '0) ? TICK_WIDTH'(1) : BIT_TICKS;
                  byte_cnt  <= '0;
               end else begin
                  state <= F_IDLE;
               end
            end
            F_LOAD: state <= F_SEND;
            F_SEND: begin
               if (char_end) begin
                  if (last_byte) begin
                     state      <= F_DONE;
                     FRAME_DONE <= 1'b1;
                     CMD_READY  <= 1'b1;
                     BUSY       <= 1'b0;
                  end else begin
`ifdef UART_CMD_ENC_IDLE_GAP_EN
                     state   <= F_GAP;
                     gap_cnt <= gap_len - 1'b1;
`else
                     byte_cnt <= byte_cnt + 2'd1;
`endif
                  end
               end
            end
`ifdef UART_CMD_ENC_IDLE_GAP_EN
            F_GAP: begin
               if (gap_cnt == '0) begin
                  state    <= F_SEND;
                  byte_cnt <= byte_cnt + 2'd1;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
`endif
            default: state <= F_IDLE;
         endcase
      end
   end

   uart_char_tx #(
      .DATA_WIDTH (DATA_WIDTH),
      .TICK_WIDTH (TICK_WIDTH)
   ) u_char_tx (
      .CLK      (CLK),
      .RST      (RST),
      .load     (load),
      .data     (load_byte),
      .par_en   (par_en_q),
      .par_typ  (par_typ_q),
      .ticks    (ticks_q),
      .tx       (TX_OUT),
      .char_end (char_end)
   );

endmodule
